sample_ring_buffer_p: RTL and testbench

Parametrised single-clock ring buffer between the mixer and the DAC path. It accepts mixed samples whenever space exists and throttles the generator/mixer pipeline through `o_ready`, which drives their `clk_en`. It releases exactly one sample per sample-rate tick to the DAC and handles underrun with a selectable policy. It also supports flush, fill level, a low watermark, and optional statistics.

---
 rtl/synth_pkg.sv | 7 +
 rtl/sample_ring_buffer_p_if.sv | 11 +
 rtl/sample_ring_buffer_p_sample_dpram.sv | 40 ++++
 rtl/sample_ring_buffer_p.sv | 105 ++++++++++
 tb/tb_sample_ring_buffer_p.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared synth-path types: sample width/type and the ring buffer's underrun-policy codes.
package synth_pkg;
   localparam int SAMPLE_W = 24;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   localparam int UR_HOLD = 0;
   localparam int UR_ZERO = 1;
endpackage

// File: rtl/sample_ring_buffer_p_if.sv
// Mixer -> ring buffer sample stream. o_ready doubles as the generator/mixer clk_en.
interface sample_ring_buffer_p_if
   import synth_pkg::*;
#(parameter int WIDTH = SAMPLE_W) ();
   logic [WIDTH-1:0] i_data;
   logic             i_valid;
   logic             o_ready;

   modport master (output i_data, i_valid, input o_ready);
   modport slave  (input i_data, i_valid, output o_ready);
endinterface

// File: rtl/sample_ring_buffer_p_sample_dpram.sv
// Simple dual-port sample RAM with a registered read port; clr zeroes the read register
// when no read is taking place (used for the zero-on-underrun policy).
module sample_dpram
   import synth_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int DEPTH = 128,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   input  logic             clr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_d, rdata_q;

   // Storage is deliberately not reset; only the output register is.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re)       rdata_d = mem[raddr];
      else if (clr) rdata_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/sample_ring_buffer_p.sv
// Mixer-to-DAC ring buffer: one read per sample tick, selectable underrun policy, flush.
// Define SAMPLE_BUF_STATS_EN to add saturating underrun/overrun counters.
module sample_ring_buffer_p
   import synth_pkg::*;
#(
   parameter int WIDTH         = SAMPLE_W,
   parameter int DEPTH         = 128,
   parameter int LOW_WM        = 32,
   parameter int UNDERRUN_ZERO = UR_HOLD,
   localparam int AW           = $clog2(DEPTH),
   localparam int PW           = AW + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_tick,
   sample_ring_buffer_p_if.slave    wr,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_sample,
   output logic                     o_sample_valid,
   output logic [PW-1:0]            o_level,
   output logic                     o_low,
   output logic                     o_underrun
`ifdef SAMPLE_BUF_STATS_EN
   ,
   output logic [15:0]              o_underrun_cnt,
   output logic [15:0]              o_overrun_cnt
`endif
);
   logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic          sv_d, sv_q, ur_d, ur_q;
   logic          empty, full, wr_en, rd_en, clr;

   // Status decodes only from pointer registers, so o_ready has no path from i_tick/i_valid.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign wr_en = wr.i_valid && !full && !i_flush;
   assign rd_en = i_tick && !empty && !i_flush;
   assign clr   = ur_d && (UNDERRUN_ZERO == UR_ZERO);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = i_flush ? wr_ptr_q : rd_ptr_q + PW'(rd_en);
      sv_d     = i_tick;
      ur_d     = i_tick && !rd_en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         sv_q     <= 1'b0;
         ur_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         sv_q     <= sv_d;
         ur_q     <= ur_d;
      end
   end

   sample_dpram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (wr_en),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (wr.i_data),
      .re    (rd_en),
      .raddr (rd_ptr_q[AW-1:0]),
      .clr   (clr),
      .rdata (o_sample)
   );

   assign wr.o_ready     = !full;
   assign o_level        = wr_ptr_q - rd_ptr_q;
   assign o_low          = int'(o_level) < LOW_WM;
   assign o_sample_valid = sv_q;
   assign o_underrun     = ur_q;

`ifdef SAMPLE_BUF_STATS_EN
   logic [15:0] urc_d, urc_q, ovc_d, ovc_q;
   logic        ov_ev;

   // Flush drops are intentional and are not counted as overruns.
   assign ov_ev = wr.i_valid && full && !i_flush;

   always_comb begin
      urc_d = urc_q + 16'(ur_d  && (urc_q != 16'hFFFF));
      ovc_d = ovc_q + 16'(ov_ev && (ovc_q != 16'hFFFF));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         urc_q <= '0;
         ovc_q <= '0;
      end else begin
         urc_q <= urc_d;
         ovc_q <= ovc_d;
      end
   end

   assign o_underrun_cnt = urc_q;
   assign o_overrun_cnt  = ovc_q;
`endif
endmodule

// File: tb/tb_sample_ring_buffer_p.sv
// Bench for sample_ring_buffer_p (DEPTH=8, hold policy): vector table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_sample_ring_buffer_p;
   import synth_pkg::*;

   localparam int W      = 24;
   localparam int DEPTH  = 8;
   localparam int LOW_WM = 3;
   localparam int UZ     = UR_HOLD;

   logic clk, reset, i_tick, i_flush;
   logic [W-1:0] o_sample;
   logic         o_sample_valid, o_low, o_underrun;
   logic [3:0]   o_level;
`ifdef SAMPLE_BUF_STATS_EN
   logic [15:0]  o_underrun_cnt, o_overrun_cnt;
`endif

   sample_ring_buffer_p_if #(.WIDTH(W)) wr_if ();

   sample_ring_buffer_p #(.WIDTH(W), .DEPTH(DEPTH), .LOW_WM(LOW_WM), .UNDERRUN_ZERO(UZ)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_tick         (i_tick),
      .wr             (wr_if.slave),
      .i_flush        (i_flush),
      .o_sample       (o_sample),
      .o_sample_valid (o_sample_valid),
      .o_level        (o_level),
      .o_low          (o_low),
      .o_underrun     (o_underrun)
`ifdef SAMPLE_BUF_STATS_EN
      ,
      .o_underrun_cnt (o_underrun_cnt),
      .o_overrun_cnt  (o_overrun_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec, n_bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a FIFO queue of samples plus the last value shown to the DAC.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_sample;
   bit           m_sv, m_ur;
   int           m_urc, m_ovc;

   task automatic model_reset();
      mq.delete();
      m_sample = '0; m_sv = 0; m_ur = 0; m_urc = 0; m_ovc = 0;
   endtask

   task automatic model_step(input bit f, input bit v, input bit t, input logic [W-1:0] d);
      bit was_full  = (mq.size() == DEPTH);
      bit was_empty = (mq.size() == 0);
      m_sv = t;
      m_ur = t && (f || was_empty);
      if (m_ur && UZ == UR_ZERO) m_sample = '0;
      if (f) mq.delete();
      else begin
         if (t && !was_empty) m_sample = mq.pop_front();
         if (v) begin
            if (was_full) m_ovc++;
            else          mq.push_back(d);
         end
      end
      if (m_ur) m_urc++;
   endtask

   // Drive one cycle's inputs, let the edge happen, and advance the model.
   task automatic cycle(input bit f, input bit v, input bit t, input logic [W-1:0] d);
      i_flush = f; wr_if.i_valid = v; i_tick = t; wr_if.i_data = d;
      @(posedge clk);
      #1;
      model_step(f, v, t, d);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_sample"}, o_sample, m_sample);
      chk({tag, "_sv"},     o_sample_valid, m_sv);
      chk({tag, "_ur"},     o_underrun, m_ur);
      chk({tag, "_level"},  o_level, mq.size());
      chk({tag, "_ready"},  wr_if.o_ready, mq.size() != DEPTH);
      chk({tag, "_low"},    o_low, mq.size() < LOW_WM);
`ifdef SAMPLE_BUF_STATS_EN
      chk({tag, "_urc"},    o_underrun_cnt, m_urc);
      chk({tag, "_ovc"},    o_overrun_cnt, m_ovc);
`endif
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_sample"}, o_sample, 0);
      chk({tag, "_sv"},     o_sample_valid, 0);
      chk({tag, "_ur"},     o_underrun, 0);
      chk({tag, "_level"},  o_level, 0);
      chk({tag, "_ready"},  wr_if.o_ready, 1);
      chk({tag, "_low"},    o_low, 1);
   endtask

   task automatic do_reset();
      i_flush = 0; wr_if.i_valid = 0; i_tick = 0; wr_if.i_data = '0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      model_reset();
   endtask

   typedef struct {
      bit f, v, t;
      logic [W-1:0] d;
      logic [W-1:0] s;
      bit sv, ur;
      int lvl;
      bit rdy;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit f, v, t, input logic [W-1:0] d, input logic [W-1:0] s,
                      input bit sv, ur, input int lvl, input bit rdy);
      vec_t x;
      x.f = f; x.v = v; x.t = t; x.d = d; x.s = s; x.sv = sv; x.ur = ur; x.lvl = lvl; x.rdy = rdy;
      tbl.push_back(x);
   endtask

   initial begin
      logic [W-1:0] got[$];
      bit prev_t;
      int wprob;
      n_vec = 0; n_bad = 0;
      reset = 1;
      i_flush = 0; wr_if.i_valid = 0; i_tick = 0; wr_if.i_data = '0;
      model_reset();
      #3 check_reset_vals("rst");
      do_reset();
      check_reset_vals("rst_rel");

      // Basic read-out, fill to full with a dropped write, underrun, empty write+tick, flush collision.
      add(0,1,0,24'h1, 0,0,0,1,1);
      add(0,1,0,24'h2, 0,0,0,2,1);
      add(0,1,0,24'h3, 0,0,0,3,1);
      add(0,0,0,0,     0,0,0,3,1);
      add(0,0,1,0,     1,1,0,2,1);
      add(0,0,0,0,     1,0,0,2,1);
      add(0,0,1,0,     2,1,0,1,1);
      add(0,0,0,0,     2,0,0,1,1);
      add(0,0,1,0,     3,1,0,0,1);
      add(0,0,0,0,     3,0,0,0,1);
      for (int k = 0; k < 8; k++) add(0,1,0,24'h10 + 24'(k), 3,0,0,k+1, (k+1) < 8);
      add(0,1,0,24'h00ABCD, 3,0,0,8,0);
      add(0,0,1,0,          24'h10,0+1,0,7,1);
      add(1,0,0,0,          24'h10,0,0,0,1);
      add(0,1,0,24'h7FFFFF, 24'h10,0,0,1,1);
      add(0,0,1,0,          24'h7FFFFF,1,0,0,1);
      add(0,0,0,0,          24'h7FFFFF,0,0,0,1);
      add(0,0,1,0,          24'h7FFFFF,1,1,0,1);
      add(0,0,0,0,          24'h7FFFFF,0,0,0,1);
      add(0,1,1,24'h55,     24'h7FFFFF,1,1,1,1);
      add(0,0,0,0,          24'h7FFFFF,0,0,1,1);
      add(0,0,1,0,          24'h55,1,0,0,1);
      for (int k = 0; k < 5; k++) add(0,1,0,24'h20 + 24'(k), 24'h55,0,0,k+1,1);
      add(1,1,1,24'h99,     24'h55,1,1,0,1);
      add(0,0,0,0,          24'h55,0,0,0,1);
      add(0,0,1,0,          24'h55,1,1,0,1);

      foreach (tbl[i]) begin
         cycle(tbl[i].f, tbl[i].v, tbl[i].t, tbl[i].d);
         chk($sformatf("v%0d_sample", i), o_sample, tbl[i].s);
         chk($sformatf("v%0d_sv", i),     o_sample_valid, tbl[i].sv);
         chk($sformatf("v%0d_ur", i),     o_underrun, tbl[i].ur);
         chk($sformatf("v%0d_level", i),  o_level, tbl[i].lvl);
         chk($sformatf("v%0d_ready", i),  wr_if.o_ready, tbl[i].rdy);
      end
`ifdef SAMPLE_BUF_STATS_EN
      chk("tbl_urc", o_underrun_cnt, 4);
      chk("tbl_ovc", o_overrun_cnt, 1);
`endif

      // Reset asserted between edges with five samples buffered.
      do_reset();
      cycle(0,1,0,24'h000111); cycle(0,0,1,0); cycle(0,0,0,0);
      for (int k = 0; k < 5; k++) cycle(0,1,0,24'h40 + 24'(k));
      cycle(0,0,0,0);
      check_model("pre_rst");
      #3 reset = 1;
      #1 check_reset_vals("mid_rst");
      model_reset();
      #1 reset = 0;
      @(posedge clk); #1;
      cycle(0,0,1,0);
      check_model("post_rst_tick");
      chk("post_rst_ur", o_underrun, 1);
      chk("post_rst_zero", o_sample, 0);

      // Wrap-around: ramp 0..19 through the 8-entry ring.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(0,1,(i > 0),24'(i));
         check_model("wrap");
         if (o_sample_valid) got.push_back(o_sample);
         chk("wrap_noUR", o_underrun, 0);
         cycle(0,0,0,0);
      end
      cycle(0,0,1,0);
      if (o_sample_valid) got.push_back(o_sample);
      chk("wrap_noUR_last", o_underrun, 0);
      chk("wrap_count", got.size(), 20);
      foreach (got[k]) chk($sformatf("wrap_rd%0d", k), got[k], k);

      // Randomized traffic in alternating fill-heavy and drain-heavy phases.
      do_reset();
      prev_t = 0;
      for (int c = 0; c < 4000; c++) begin
         bit f, v, t;
         wprob = ((c / 200) % 2 == 0) ? 45 : 15;
         t = !prev_t && ($urandom_range(0, 2) == 0);
         v = ($urandom_range(0, 99) < wprob);
         f = ($urandom_range(0, 99) < 2);
         cycle(f, v, t, W'($urandom));
         check_model("rnd");
         prev_t = t;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
